load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 tb/tb_load_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Bridges the core's load/store requests onto a simple req/ready memory
//   port.  One access is in flight at a time.  A request captured in IDLE
//   moves to REQ, where it waits for mem_ready.  DONE then pulses for one
//   cycle.  stall holds the PC and RegWrite frozen until DONE.
//
// Optional feature (macro LSU_MISALIGN_TRAP_EN):
//   Misaligned half/word accesses skip memory and complete with fault=1.
//   When the macro is undefined, the fault port and trap path are absent.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   MemRead, MemWrite   : access request from the control unit (both = store)
//   funct3              : access size/sign (instr[14:12])
//   addr, store_data    : byte address and store operand
//   stall               : freeze PC update / RegWrite while high
//   done                : one-cycle access-complete pulse
//   load_data           : extended load result for write-back
//   mem_req, mem_we     : memory request / write strobe
//   mem_addr, mem_wdata : word-aligned address, lane-replicated write data
//   mem_be              : byte enables
//   mem_ready           : memory handshake (mem_rdata valid on loads)
//   mem_rdata           : memory read word
//   fault               : misalignment trap flag (LSU_MISALIGN_TRAP_EN only)
// ---------------------------------------------------------------------------
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] store_data,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] load_data,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic             fault,
`endif
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     state;
  logic [1:0] off_q;    // byte offset of the access in flight
  logic [2:0] f3_q;     // size/sign of the access in flight
  logic       load_q;   // access in flight is a load

  logic [3:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] sh_b, sh_h, ext_c;

  // Requesting cycle stalls combinationally so the PC never slips past it.
  assign stall = ((state == IDLE) && (MemRead || MemWrite)) || (state == REQ);

  // Lane selection and write-data replication for the incoming request.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down, then extend it by size and sign.
  always_comb begin
    sh_b  = mem_rdata >> {off_q, 3'b000};
    sh_h  = mem_rdata >> {off_q[1], 4'b0000};
    ext_c = mem_rdata;
    case (f3_q)
      3'b000:  ext_c = {{(WIDTH-8){sh_b[7]}}, sh_b[7:0]};
      3'b001:  ext_c = {{(WIDTH-16){sh_h[15]}}, sh_h[15:0]};
      3'b100:  ext_c = {{(WIDTH-8){1'b0}}, sh_b[7:0]};
      3'b101:  ext_c = {{(WIDTH-16){1'b0}}, sh_h[15:0]};
      default: ext_c = mem_rdata;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_c;
  always_comb begin
    mis_c = 1'b0;
    if (funct3[1:0] == 2'b01)
      mis_c = addr[0];
    else if (funct3[1:0] != 2'b00)
      mis_c = (addr[1:0] != 2'b00);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      off_q     <= '0;
      f3_q      <= '0;
      load_q    <= 1'b0;
      load_data <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      done      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (MemRead || MemWrite) begin
            off_q  <= addr[1:0];
            f3_q   <= funct3;
            load_q <= !MemWrite;  // store wins when both are requested
`ifdef LSU_MISALIGN_TRAP_EN
            if (mis_c) begin
              state <= DONE;
              done  <= 1'b1;
              fault <= 1'b1;
            end else
`endif
            begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
            end
          end
        end
        REQ: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            // mem_rdata is only valid on the handshake edge, so extend it now.
            if (load_q)
              load_data <= ext_c;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed vectors for load_store_unit.  The stimulus task pushes the
//   expected memory transaction and the expected load_data.  Each access
//   also checks the stall/done timing and holds the outputs stable in REQ.
//   A separate monitor compares each memory handshake and the load_data
//   after every done pulse against those queues.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        fault;
`endif

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
`ifdef LSU_MISALIGN_TRAP_EN
    .fault      (fault),
`endif
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] ld_q[$];
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: memory handshakes and post-done load_data against the queues.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    mem_t        e;
    logic [31:0] el;
    if (mem_req && mem_ready) begin
      if (mem_q.size() == 0) check("mem_q_underflow", mem_q.size(), 1);
      else begin
        e = mem_q.pop_front();
        check("hs_mem_we",   mem_we,   e.we);
        check("hs_mem_addr", mem_addr, e.addr);
        check("hs_mem_be",   mem_be,   e.be);
        if (e.we) check("hs_mem_wdata", mem_wdata, e.wdata);
      end
    end
    if (done_d) begin
      if (ld_q.size() == 0) check("ld_q_underflow", ld_q.size(), 1);
      else begin
        el = ld_q.pop_front();
        check("load_data", load_data, el);
      end
    end
    done_d = done;
  end

  // One complete access.  delay = mem_ready low cycles before the handshake.
  task automatic access(input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int delay, input bit trap,
                        input mem_t exp, input logic [31:0] exp_ld);
    if (!trap) mem_q.push_back(exp);
    ld_q.push_back(exp_ld);
    @(posedge clk); #1;
    MemRead = mr; MemWrite = mw; funct3 = f3; addr = a; store_data = sd;
    @(negedge clk);
    check("stall_request_cycle", stall, 1'b1);
    check("mem_req_idle", mem_req, 1'b0);
    @(posedge clk); #1;
    // Scramble inputs to prove the request was registered.
    MemRead = 1'b0; MemWrite = 1'b0;
    addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
    if (!trap) begin
      for (int i = 0; i <= delay; i++) begin
        if (i == delay) begin mem_ready = 1'b1; mem_rdata = rd; end
        @(negedge clk);
        check("req_mem_req",  mem_req,  1'b1);
        check("req_stall",    stall,    1'b1);
        check("req_done",     done,     1'b0);
        check("req_mem_we",   mem_we,   exp.we);
        check("req_mem_addr", mem_addr, exp.addr);
        check("req_mem_be",   mem_be,   exp.be);
        if (exp.we) check("req_mem_wdata", mem_wdata, exp.wdata);
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_stall", stall, 1'b0);
    check("done_mem_req", mem_req, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("done_fault", fault, trap);
`endif
    @(negedge clk);
    check("done_once", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

  logic [31:0] cur_ld;

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    addr = '0; store_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mem_req",   mem_req,   1'b0);
    check("rst_mem_we",    mem_we,    1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_stall",     stall,     1'b0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_mem_addr",  mem_addr,  32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be",    mem_be,    4'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("rst_fault",     fault,     1'b0);
`endif

    // SW 0x104, immediate ready.
    access(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0,
           '{we:1'b1, addr:32'h104, wdata:32'hDEADBEEF, be:4'b1111}, 32'h0);
    // LB / LBU from the top byte.
    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 0,
           '{we:1'b0, addr:32'h100, wdata:32'h0, be:4'b1000}, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 0,
           '{we:1'b0, addr:32'h100, wdata:32'h0, be:4'b1000}, 32'h00000080);
    // SH 0x22, ready delayed 4 cycles (5 REQ cycles).
    access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 4, 0,
           '{we:1'b1, addr:32'h20, wdata:32'hABCDABCD, be:4'b1100}, 32'h00000080);
    // Half loads, both halves, signed and unsigned.
    access(1, 0, 3'b001, 32'h22, 32'h0, 32'h80011234, 0, 0,
           '{we:1'b0, addr:32'h20, wdata:32'h0, be:4'b1100}, 32'hFFFF8001);
    access(1, 0, 3'b101, 32'h20, 32'h0, 32'h1234F00D, 0, 0,
           '{we:1'b0, addr:32'h20, wdata:32'h0, be:4'b0011}, 32'h0000F00D);
    access(1, 0, 3'b001, 32'h20, 32'h0, 32'h1234F00D, 0, 0,
           '{we:1'b0, addr:32'h20, wdata:32'h0, be:4'b0011}, 32'hFFFFF00D);
    // LW with one wait cycle.
    access(1, 0, 3'b010, 32'h108, 32'h0, 32'hCAFEF00D, 1, 0,
           '{we:1'b0, addr:32'h108, wdata:32'h0, be:4'b1111}, 32'hCAFEF00D);
    // SB lane 1.
    access(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, 0,
           '{we:1'b1, addr:32'h200, wdata:32'h78787878, be:4'b0010}, 32'hCAFEF00D);
    // LB positive byte, lane 1.
    access(1, 0, 3'b000, 32'h301, 32'h0, 32'h00007F00, 0, 0,
           '{we:1'b0, addr:32'h300, wdata:32'h0, be:4'b0010}, 32'h0000007F);

    // LW abandoned by reset in its second REQ cycle.
    @(posedge clk); #1;
    MemRead = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    check("abort_req_cycle1", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_req_cycle2", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_req",   mem_req,   1'b0);
    check("abort_stall",     stall,     1'b0);
    check("abort_done",      done,      1'b0);
    check("abort_load_data", load_data, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end

    // LW to 0x102: trap when enabled, otherwise aligned down to 0x100.
`ifdef LSU_MISALIGN_TRAP_EN
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 1,
           '{we:1'b0, addr:32'h100, wdata:32'h0, be:4'b1111}, 32'h0);
    cur_ld = 32'h0;
`else
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 0,
           '{we:1'b0, addr:32'h100, wdata:32'h0, be:4'b1111}, 32'h11223344);
    cur_ld = 32'h11223344;
`endif

    // MemRead and MemWrite together: store, load_data untouched.
    access(1, 1, 3'b010, 32'h300, 32'h55AA55AA, 32'hFFFFFFFF, 0, 0,
           '{we:1'b1, addr:32'h300, wdata:32'h55AA55AA, be:4'b1111}, cur_ld);

    repeat (2) @(negedge clk);
    check("mem_q_drained", mem_q.size(), 0);
    check("ld_q_drained",  ld_q.size(),  0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
